// File: rtl/simon_led_pwm_ctrl.sv
// N-channel RGB LED driver for the Simon board: idle PWM dimming, single-channel hold,
// and a counted flash sequence with busy/done handshake. All LED outputs are registered.
module simon_led_pwm_ctrl #(
    parameter int                  N_LEDS        = 4,
    parameter logic [3*N_LEDS-1:0] COLOR_TABLE   = 12'b011_100_001_010,
    parameter int                  PWM_PERIOD    = 250000,
    parameter int                  DIM_DUTY      = 50000,
    parameter int                  FLASH_ON_CYC  = 12500000,
    parameter int                  FLASH_OFF_CYC = 5000000,
    localparam int                 SW            = $clog2(N_LEDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  idle_dim_en,
    input  logic                  hold,
    input  logic [SW-1:0]         sel,
    input  logic                  flash_start,
    input  logic [3:0]            flash_count,
    input  logic [N_LEDS-1:0]     flash_mask,
    output logic                  busy,
    output logic                  done,
    output logic [3*N_LEDS-1:0]   led_rgb
);

    localparam int PW   = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int TMAX = (FLASH_ON_CYC > FLASH_OFF_CYC) ? FLASH_ON_CYC : FLASH_OFF_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF
    } state_t;

    state_t               state, state_next;
    logic [PW-1:0]        pwm_cnt;
    logic [TW-1:0]        timer;
    logic [3:0]           remaining;
    logic [N_LEDS-1:0]    flash_mask_q;
    logic [3*N_LEDS-1:0]  led_next;
    logic                 dim_on;
    logic                 on_last;
    logic                 off_last;
    logic                 start_ok;

    assign dim_on   = (pwm_cnt < PW'(DIM_DUTY));
    assign on_last  = (timer == TW'(FLASH_ON_CYC - 1));
    assign off_last = (timer == TW'(FLASH_OFF_CYC - 1));
    assign start_ok = flash_start && (flash_count != 4'd0);

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            S_IDLE:  if (start_ok) state_next = S_ON;
            S_ON:    if (on_last) state_next = S_OFF;
            S_OFF:   if (off_last) state_next = (remaining == 4'd1) ? S_IDLE : S_ON;
            default: state_next = S_IDLE;
        endcase
    end

    // Per-channel colour priority: flash > hold > idle dim > black.
    always_comb begin
        busy     = (state != S_IDLE);
        led_next = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            if (busy && flash_mask_q[i])
                led_next[3*i +: 3] = (state == S_ON) ? COLOR_TABLE[3*i +: 3] : 3'b000;
            else if (hold && (sel == SW'(i)))
                led_next[3*i +: 3] = COLOR_TABLE[3*i +: 3];
            else if (idle_dim_en && dim_on)
                led_next[3*i +: 3] = COLOR_TABLE[3*i +: 3];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt      <= '0;
            timer        <= '0;
            remaining    <= '0;
            flash_mask_q <= '0;
            done         <= 1'b0;
            led_rgb      <= '0;
        end else begin
            pwm_cnt <= (pwm_cnt == PW'(PWM_PERIOD - 1)) ? '0 : pwm_cnt + 1'b1;
            led_rgb <= led_next;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    timer <= '0;
                    if (flash_start) begin
                        if (flash_count != 4'd0) begin
                            flash_mask_q <= flash_mask;
                            remaining    <= flash_count;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_ON: timer <= on_last ? '0 : timer + 1'b1;
                S_OFF: begin
                    if (off_last) begin
                        timer     <= '0;
                        remaining <= remaining - 4'd1;
                        if (remaining == 4'd1) done <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: timer <= '0;
            endcase
        end
    end

endmodule
